// File: rtl/lvda_timing_pkg.sv
// Shared types for the LVDA timing sequencer: sub-phase and sequencer state
// encodings plus the bit-time counter width.
package lvda_timing_pkg;

  localparam int unsigned BIT_W = 4;

  typedef enum logic [1:0] {
    PH_W,
    PH_X,
    PH_Y,
    PH_Z
  } phase_t;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_RUN,
    SQ_STEP1
  } seq_state_t;

endpackage

// File: rtl/lvda_phase_counter.sv
// Tick counter and W->X->Y->Z sub-phase rotation for one bit time.
// Held at W/tick 0 while disabled, so every enabled run starts cleanly on W.
module lvda_phase_counter #(
  parameter int unsigned TICKS_PER_SUB = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] phase_oh,
  output logic       bt_end
);
  import lvda_timing_pkg::*;

  localparam int unsigned TW = (TICKS_PER_SUB > 1) ? $clog2(TICKS_PER_SUB) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SUB - 1);

  logic [TW-1:0] tick;
  phase_t        phase;
  phase_t        phase_next;
  logic          sub_end;

  assign sub_end = (tick == TICK_LAST);

  always_comb begin
    phase_next = PH_W;
    unique case (phase)
      PH_W: phase_next = PH_X;
      PH_X: phase_next = PH_Y;
      PH_Y: phase_next = PH_Z;
      PH_Z: phase_next = PH_W;
      default: phase_next = PH_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick  <= '0;
      phase <= PH_W;
    end else if (sub_end) begin
      tick  <= '0;
      phase <= phase_next;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Bit 3 is W, bit 0 is Z; all lines forced low while disabled.
  always_comb begin
    phase_oh = '0;
    bt_end   = 1'b0;
    if (enable) begin
      unique case (phase)
        PH_W: phase_oh = 4'b1000;
        PH_X: phase_oh = 4'b0100;
        PH_Y: phase_oh = 4'b0010;
        PH_Z: phase_oh = 4'b0001;
        default: phase_oh = '0;
      endcase
      bt_end = (phase == PH_Z) && sub_end;
    end
  end

endmodule

// File: rtl/lvda_timing_sequencer.sv
// LVDA delay-line phase sequencer: run/halt/single-step state machine and
// bit-time counter around the sub-phase counter.
module lvda_timing_sequencer #(
  parameter int unsigned BIT_TIMES     = 14,
  parameter int unsigned TICKS_PER_SUB = 2
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       CLR,
  output logic       WDA,
  output logic       XDA,
  output logic       YDA,
  output logic       ZDA,
  output logic [3:0] BIT,
  output logic       BT_END,
  output logic       WORD_END,
  output logic       BUSY
);
  import lvda_timing_pkg::*;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_TIMES - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             busy;
  logic             bt_end;
  logic [3:0]       phase_oh;
  logic [BIT_W-1:0] bit_cnt;

  assign busy = (state != SQ_IDLE);

  lvda_phase_counter #(
    .TICKS_PER_SUB(TICKS_PER_SUB)
  ) u_phase (
    .clk      (SIM_CLK),
    .rst      (SIM_RST),
    .enable   (busy),
    .phase_oh (phase_oh),
    .bt_end   (bt_end)
  );

  // Leaving RUN or STEP1 only happens on BT_END, which keeps halts on a
  // bit-time boundary and lets a live RUN carry straight into the next bit.
  always_comb begin
    state_next = state;
    unique case (state)
      SQ_IDLE: begin
        if (RUN)       state_next = SQ_RUN;
        else if (STEP) state_next = SQ_STEP1;
      end
      SQ_RUN, SQ_STEP1: begin
        if (bt_end) state_next = RUN ? SQ_RUN : SQ_IDLE;
      end
      default: state_next = SQ_IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) state <= SQ_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      bit_cnt <= '0;
    end else if (state == SQ_IDLE) begin
      if (CLR) bit_cnt <= '0;
    end else if (bt_end) begin
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign {WDA, XDA, YDA, ZDA} = phase_oh;
  assign BIT      = bit_cnt;
  assign BT_END   = bt_end;
  assign WORD_END = bt_end && (bit_cnt == BIT_LAST);
  assign BUSY     = busy;

endmodule

// File: tb/tb_lvda_timing_sequencer.sv
// Self-checking bench for lvda_timing_sequencer: directed scenarios plus random
// control traffic, checked every cycle against a cycle-position reference model.
module tb_lvda_timing_sequencer;

  localparam int BT = 14;
  localparam int T  = 2;
  localparam int BIT_CYC = 4 * T;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST, RUN, STEP, CLR;
  logic       WDA, XDA, YDA, ZDA;
  logic [3:0] BIT;
  logic       BT_END, WORD_END, BUSY;

  int compared   = 0;
  int mismatched = 0;
  int busy_cnt   = 0;

  // Reference model: active flag, cycle offset inside the bit time, bit number.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_bit    = 0;

  lvda_timing_sequencer #(
    .BIT_TIMES     (BT),
    .TICKS_PER_SUB (T)
  ) dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .RUN      (RUN),
    .STEP     (STEP),
    .CLR      (CLR),
    .WDA      (WDA),
    .XDA      (XDA),
    .YDA      (YDA),
    .ZDA      (ZDA),
    .BIT      (BIT),
    .BT_END   (BT_END),
    .WORD_END (WORD_END),
    .BUSY     (BUSY)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic s, input logic c, input logic rs);
    if (rs) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_bit    = 0;
    end else if (!m_active) begin
      if (c) m_bit = 0;
      if (r || s) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (m_pos == BIT_CYC - 1) begin
      m_bit    = (m_bit + 1) % BT;
      m_pos    = 0;
      m_active = r;
    end else begin
      m_pos++;
    end
  endfunction

  task automatic check_outputs();
    logic [3:0] exp_ph;
    logic       exp_end;
    exp_ph  = m_active ? 4'(4'b1000 >> (m_pos / T)) : 4'b0000;
    exp_end = m_active && (m_pos == BIT_CYC - 1);
    chk("phases", 32'({WDA, XDA, YDA, ZDA}), 32'(exp_ph));
    chk("onehot", 32'($countones({WDA, XDA, YDA, ZDA})), BUSY ? 32'd1 : 32'd0);
    chk("busy", 32'(BUSY), 32'(m_active));
    chk("bit", 32'(BIT), 32'(m_bit));
    chk("bt_end", 32'(BT_END), 32'(exp_end));
    chk("word_end", 32'(WORD_END), 32'(exp_end && (m_bit == BT - 1)));
  endtask

  task automatic tick(input logic r, input logic s, input logic c, input logic rs);
    RUN = r; STEP = s; CLR = c; SIM_RST = rs;
    @(posedge SIM_CLK);
    model_step(r, s, c, rs);
    @(negedge SIM_CLK);
    check_outputs();
    if (BUSY) busy_cnt++;
  endtask

  // Keep running until the model reaches the given bit/offset; bounded.
  task automatic run_until(input int b, input int p);
    int n = 0;
    while (!(m_active && m_bit == b && m_pos == p) && n < 400) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("run_until_reached", 32'(n < 400), 32'd1);
  endtask

  task automatic idle_wait();
    int n = 0;
    while (m_active && n < 40) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("idle_reached", 32'(n < 40), 32'd1);
  endtask

  initial begin
    logic r;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_bit", 32'(BIT), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);

    // Continuous run through one full word and past the wrap.
    for (int c = 1; c <= 114; c++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (c == 1)   chk("wda_c1", 32'(WDA), 32'd1);
      if (c == 3)   chk("xda_c3", 32'(XDA), 32'd1);
      if (c == 5)   chk("yda_c5", 32'(YDA), 32'd1);
      if (c == 8)   chk("bt_end_c8", 32'(BT_END), 32'd1);
      if (c == 9)   chk("bit_c9", 32'(BIT), 32'd1);
      if (c == 112) chk("word_end_c112", 32'(WORD_END), 32'd1);
      if (c == 113) chk("bit_wrap", 32'(BIT), 32'd0);
    end

    // Halt mid-X of bit 5, then resume from the held bit.
    run_until(5, T);
    idle_wait();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_bit", 32'(BIT), 32'd6);
    chk("halt_lines", 32'({WDA, XDA, YDA, ZDA}), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_wda", 32'(WDA), 32'd1);
    chk("resume_bit", 32'(BIT), 32'd6);

    // Halt at BIT=3, then single-step with a second STEP ignored while busy.
    run_until(2, 1);
    idle_wait();
    busy_cnt = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("step_busy_cycles", 32'(busy_cnt), 32'(BIT_CYC));
    chk("step_bit", 32'(BIT), 32'd4);

    // CLR in IDLE at BIT=9 zeroes; CLR during RUN at BIT=9 is ignored.
    run_until(8, 0);
    idle_wait();
    chk("pre_clr_bit", 32'(BIT), 32'd9);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_idle_bit", 32'(BIT), 32'd0);
    run_until(9, 2);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    run_until(10, 0);
    chk("clr_run_ignored", 32'(BIT), 32'd10);

    // Reset in the middle of Y of bit 7, then restart from bit 0.
    run_until(7, 2 * T + 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_bit", 32'(BIT), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_restart_wda", 32'(WDA), 32'd1);

    // STEP, then RUN raised during the step: no idle cycle between bits.
    idle_wait();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    repeat (3 * BIT_CYC) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("step_to_run_no_gap", 32'(busy_cnt), 32'(3 * BIT_CYC));

    // Random control traffic.
    r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) r = ~r;
      tick(r, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lvda_timing_sequencer.md
Name: lvda_timing_sequencer

Overview:
- Generates the four LVDA delay-line phase drives WDA, XDA, YDA and ZDA, plus the bit-time count that the timing buffer modules fan out.
- Sequences one bit time as W, X, Y, Z sub-phases, in order. Bit times are grouped into a word of BIT_TIMES.
- Provides run, halt and single-step control so the simulated LVDA can be started, frozen at a bit-time boundary, or stepped one bit time at a time from the test harness.

Parameters:
- BIT_TIMES, 14: bit times per word. Legal range 2..16.
- TICKS_PER_SUB, 2: SIM_CLK cycles per sub-phase. Legal range 1..16.

Ports:
- SIM_CLK  input  1  simulation clock
- SIM_RST  input  1  reset; synchronous, active-high
- RUN  input  1  level; continuous sequencing while high
- STEP  input  1  pulse; execute exactly one bit time, used when not running
- CLR  input  1  pulse; zero the bit counter, honoured only in IDLE
- WDA  output  1  W phase drive
- XDA  output  1  X phase drive
- YDA  output  1  Y phase drive
- ZDA  output  1  Z phase drive
- BIT  output  4  current bit time, 0..BIT_TIMES-1
- BT_END  output  1  one-cycle strobe on the last tick of Z
- WORD_END  output  1  one-cycle strobe coincident with BT_END when BIT==BIT_TIMES-1
- BUSY  output  1  high whenever a phase line is active

Behaviour:
- All state updates on rising SIM_CLK. SIM_RST sampled high forces IDLE, mid-operation included:
  - WDA/XDA/YDA/ZDA=0, BIT=0, BT_END=0, WORD_END=0, BUSY=0, tick counter=0, sub-phase=W.
- States:
  - IDLE: all phase lines low.
  - RUN: continuous.
  - STEP1: one bit time, then IDLE.
- IDLE -> RUN when RUN is sampled high. IDLE -> STEP1 when STEP is sampled high and RUN is low. RUN has priority over STEP.
- Latency: in the cycle after the request is sampled, WDA=1 and BUSY=1.
- Sub-phase timing:
  - Exactly one phase line is high while BUSY, never two (one-hot).
  - Each line stays high for TICKS_PER_SUB consecutive cycles.
  - Order is W->X->Y->Z, and Z's last tick is followed directly by W of the next bit time, with no gap.
  - One bit time = 4*TICKS_PER_SUB cycles.
- Bit counter:
  - Increments on the cycle after BT_END.
  - Wraps from BIT_TIMES-1 to 0; WORD_END asserts together with BT_END on the wrapping bit.
- Halt: RUN deasserted while in RUN completes the current bit time through Z, then enters IDLE. Stopping only at a bit-time boundary is mandatory, so no partial sub-phase is ever emitted.
  - BIT then holds the next bit number.
  - If RUN is high again on the BT_END cycle, sequencing continues without a gap.
- STEP1:
  - Runs one full bit time, then enters IDLE.
  - STEP pulses during STEP1 or RUN are ignored (not queued).
  - RUN asserted during STEP1 converts it to RUN seamlessly at the next boundary, with no IDLE cycle.
- CLR in IDLE zeros BIT on the next cycle. CLR in RUN or STEP1 is ignored.
- CLR together with RUN or STEP in IDLE: BIT zeroed and the sequence starts at bit 0.
- Resuming from IDLE continues from the held BIT value.
- Tick counter width is $clog2(TICKS_PER_SUB) with a minimum of 1. BIT is 4 bits; the upper bits are zero when BIT_TIMES<16.

Decomposition:
- Shared package lvda_timing_pkg:
  - sub-phase enum (PH_W, PH_X, PH_Y, PH_Z)
  - sequencer state enum (SQ_IDLE, SQ_RUN, SQ_STEP1)
  - BIT_W=4
- One sub-module, lvda_phase_counter: the tick counter plus sub-phase rotation.
  - Inputs: enable.
  - Outputs: one-hot phase and the end-of-bit strobe.
- The top level holds the state machine and the bit counter.

Test Plan:
- Reset then RUN=1 held, TICKS_PER_SUB=2, BIT_TIMES=14:
  - WDA high on cycles 1-2, XDA on 3-4, YDA on 5-6, ZDA on 7-8.
  - BT_END on cycle 8, BIT=1 on cycle 9.
  - WORD_END on cycle 112, then BIT=0.
- RUN dropped mid-X of bit 5: Y and Z complete, BT_END fires, then IDLE with BIT=6 and all lines low.
  - RUN reasserted: WDA next cycle, BIT=6.
- STEP pulse in IDLE at BIT=3: exactly 8 busy cycles, BIT=4, IDLE.
  - A second STEP during busy is ignored, so only 8 cycles total.
- CLR with BIT=9 in IDLE -> BIT=0. CLR during RUN at BIT=9 -> no effect, BIT advances to 10.
- SIM_RST asserted mid-Y of bit 7: next cycle all outputs 0, BIT=0, IDLE.
  - Then RUN restarts from W with BIT=0.
- STEP then RUN asserted during the step: continuous phases with no idle cycle between bit times.
  - Checker asserts one-hot phase lines every cycle throughout.
